regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
- Writer side of the register-file write port: collects writeback results from two producers (memory/load unit and ALU), buffers them in order, and issues at most one write per cycle into the regfile through the w_enable / w_addr1 / w_data1 port.
- Also exports a pending-register scoreboard so decode can stall on operands whose writes are still queued.
- Sits between the EX/MEM stages and the regfile.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register address width (2^ADDR_WIDTH registers)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  load-unit result valid
- mem_ready  out  1  queue accepts the mem result this cycle
- mem_addr  in  ADDR_WIDTH  destination register
- mem_data  in  DATA_WIDTH  result data
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  queue accepts the ALU result this cycle
- alu_addr  in  ADDR_WIDTH  destination register
- alu_data  in  DATA_WIDTH  result data
- w_enable  out  1  regfile write enable (registered)
- w_addr1  out  ADDR_WIDTH  regfile write address (registered)
- w_data1  out  DATA_WIDTH  regfile write data (registered)
- pending  out  2^ADDR_WIDTH  bit r set while a write to r is queued or on the output
- count  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, immediate): FIFO emptied (rd/wr pointers and count = 0), w_enable = 0, w_addr1 = 0, w_data1 = 0, pending = 0.
  - Reset mid-operation discards all queued writes.
  - No regfile write occurs in the cycle after reset deasserts.
- Handshake: a transfer happens on a rising edge where valid && ready. Ready depends only on registered count, so there is no valid-to-ready combinational path.
  - mem_ready = (count <= DEPTH-1)
  - alu_ready = (count <= DEPTH-2)
  - Both are low during reset.
- Register 0: a transfer with addr == 0 is accepted (handshake completes) but nothing is enqueued, and pending[0] is never set.
- Simultaneous pushes: both accepted, two entries enqueued in one edge.
  - mem entry goes first (older instruction), alu entry second.
  - If one of them targets r0, only the other is enqueued, occupying one slot.
- Dequeue: on each edge, if count > 0 (pre-edge), the head is popped into the output register: w_enable <= 1, w_addr1 <= head addr, w_data1 <= head data. Otherwise w_enable <= 0 and w_addr1 / w_data1 hold their values.
- Push and pop on the same edge are allowed:
  - count_next = count + pushes - pop
  - Ready is computed on pre-edge count, so the pop frees space only for the following cycle.
- Latency:
  - Result accepted at edge k into an empty FIFO: count = 1 after edge k, w_enable = 1 after edge k+1, regfile commits at edge k+2.
  - Throughput is one write per cycle.
- Ordering:
  - Strict FIFO; writes to the same register commit in acceptance order.
  - Pointers wrap modulo DEPTH.
- Pending:
  - pending[r] = OR over valid FIFO entries with addr r, OR (w_enable && w_addr1 == r).
  - Combinational from registered state.
- Full / empty: count never exceeds DEPTH. When count == DEPTH, neither producer is ready.

Test Plan:
- Reset, then single mem push addr=3, data=0xDEADBEEF at edge 1 → count=1, pending[3]=1 after edge 1; w_enable=1, w_addr1=3, w_data1=0xDEADBEEF after edge 2; w_enable=0, pending=0 after edge 3.
- Simultaneous mem (addr=5, 0x11) and alu (addr=5, 0x22) into empty FIFO → writes appear in consecutive cycles in order 0x11 then 0x22; pending[5] stays 1 through both.
- alu push with addr=0, data=0xFFFFFFFF → alu_ready=1, handshake completes, count stays 0, w_enable never asserts, pending=0.
- Fill: hold the output path by pushing 2 entries per cycle from count=0 with DEPTH=4 → sequence of count, mem_ready and alu_ready matches the formulas; count never > 4; no entry lost or duplicated over 20 random-valid cycles, checked against a reference queue.
- Assert reset asynchronously while count=3 and w_enable=1 → all outputs zero immediately, before the next clock edge; subsequent pushes behave as from empty.
- Pointer wrap: 10 back-to-back single mem pushes, addrs 1..10 → regfile sees writes 1..10 in order, one per cycle, data intact across wrap.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// regfile_wb_queue
//
// Writer side of the register-file write port. Writeback results from the
// load unit (mem_*) and the ALU (alu_*) are collected into a small in-order
// FIFO. One entry per cycle is drained into a registered regfile write port.
// A pending-register vector tells decode which registers still have a write
// in flight, so it can stall on those operands.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   mem_valid  load-unit result valid
//   mem_ready  load-unit result accepted this cycle
//   mem_addr   load-unit destination register
//   mem_data   load-unit result data
//   alu_valid  ALU result valid
//   alu_ready  ALU result accepted this cycle
//   alu_addr   ALU destination register
//   alu_data   ALU result data
//   w_enable   regfile write enable (registered)
//   w_addr1    regfile write address (registered)
//   w_data1    regfile write data (registered)
//   pending    bit r set while a write to register r is queued or on the port
//   count      current FIFO occupancy
// ---------------------------------------------------------------------------
module regfile_wb_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_data,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_WIDTH-1:0]        alu_addr,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    output logic                         w_enable,
    output logic [ADDR_WIDTH-1:0]        w_addr1,
    output logic [DATA_WIDTH-1:0]        w_data1,
    output logic [(1<<ADDR_WIDTH)-1:0]   pending,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // The ALU threshold is one lower than the load threshold so that a
    // simultaneous push of both producers can never overflow the FIFO.
    localparam logic [CW-1:0] MEM_LIMIT = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ALU_LIMIT = CW'(DEPTH - 2);

    logic [PW-1:0]         rd_ptr_reg;
    logic [PW-1:0]         rd_ptr_next;
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         wr_ptr_next;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;

    // Addresses are held in flops because the pending vector needs to see
    // every entry at once.
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]      entry_valid;

    logic                  mem_push;
    logic                  alu_push;
    logic                  pop;
    logic [PW-1:0]         alu_slot;

    // Ready depends only on registered occupancy (plus reset), never on valid.
    always_comb begin
        mem_ready   = !reset && (count_reg <= MEM_LIMIT);
        alu_ready   = !reset && (count_reg <= ALU_LIMIT);
        // r0 writes complete the handshake but are dropped on the floor.
        mem_push    = mem_valid && mem_ready && (mem_addr != '0);
        alu_push    = alu_valid && alu_ready && (alu_addr != '0);
        pop         = (count_reg != '0);
        // The ALU entry lands behind the load entry when both are pushed.
        alu_slot    = wr_ptr_reg + PW'(mem_push);
        wr_ptr_next = wr_ptr_reg + PW'(mem_push) + PW'(alu_push);
        rd_ptr_next = rd_ptr_reg + PW'(pop);
        count_next  = count_reg + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entry storage carries no reset: validity comes from the pointers/count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_push && (wr_ptr_reg == PW'(i))) begin
                addr_mem[i] <= mem_addr;
                data_mem[i] <= mem_data;
            end else if (alu_push && (alu_slot == PW'(i))) begin
                addr_mem[i] <= alu_addr;
                data_mem[i] <= alu_data;
            end
        end
    end

    // An entry is live when its distance from the read pointer (modulo
    // DEPTH) is below the occupancy.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry_valid
            logic [PW-1:0] offset;
            assign offset          = PW'(gi) - rd_ptr_reg;
            assign entry_valid[gi] = ({1'b0, offset} < count_reg);
        end
    endgenerate

    // Output register: the head is popped whenever the FIFO was non-empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_enable <= 1'b0;
            w_addr1  <= '0;
            w_data1  <= '0;
        end else if (pop) begin
            w_enable <= 1'b1;
            w_addr1  <= addr_mem[rd_ptr_reg];
            w_data1  <= data_mem[rd_ptr_reg];
        end else begin
            w_enable <= 1'b0;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending[addr_mem[i]] = 1'b1;
            end
        end
        if (w_enable) begin
            pending[w_addr1] = 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// Testbench for regfile_wb_queue. A queue-based reference model tracks the
// FIFO contents and the registered write port; directed scenarios compare
// against constants, the randomized scenario compares against the model.
// ---------------------------------------------------------------------------
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        w_enable;
    logic [4:0]  w_addr1;
    logic [31:0] w_data1;
    logic [31:0] pending;
    logic [2:0]  count;

    int n_vec;
    int n_err;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    regfile_wb_queue #(
        .DEPTH(DEPTH),
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_addr(alu_addr),
        .alu_data(alu_data),
        .w_enable(w_enable),
        .w_addr1(w_addr1),
        .w_data1(w_data1),
        .pending(pending),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i].a] = 1'b1;
        if (m_we) p[m_wa] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
    endtask

    // One clock: drive inputs at the falling edge, advance the model across
    // the rising edge, return 1 time unit after it.
    task automatic cycle(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad);
        int   sz;
        bit   rm;
        bit   ra;
        ent_t e;
        @(negedge clk);
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        sz = mq.size();
        rm = (sz <= DEPTH - 1);
        ra = (sz <= DEPTH - 2);
        if (sz > 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_wa = e.a; m_wd = e.d;
        end else begin
            m_we = 1'b0;
        end
        if (mv && rm && ma != 5'd0) begin e.a = ma; e.d = md; mq.push_back(e); end
        if (av && ra && aa != 5'd0) begin e.a = aa; e.d = ad; mq.push_back(e); end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (w_enable !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %0b want 0", w_enable); end
        n_vec++; if (w_addr1 !== 5'd0) begin n_err++; $display("FAIL reset_waddr: got %0d want 0", w_addr1); end
        n_vec++; if (w_data1 !== 32'd0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", w_data1); end
        n_vec++; if (pending !== 32'd0) begin n_err++; $display("FAIL reset_pending: got %h want 0", pending); end
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL reset_mem_ready: got %0b want 0", mem_ready); end
        n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL reset_alu_ready: got %0b want 0", alu_ready); end
        @(negedge clk);
        reset = 1'b0;
        idle();
        n_vec++; if (w_enable !== 1'b0) begin n_err++; $display("FAIL reset_release_wen: got %0b want 0", w_enable); end
        n_vec++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %0b%0b want 11", mem_ready, alu_ready); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        cycle(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
        n_vec++; if (pending !== 32'h8) begin n_err++; $display("FAIL single_pending1: got %h want 00000008", pending); end
        n_vec++; if (w_enable !== 1'b0) begin n_err++; $display("FAIL single_wen_early: got %0b want 0", w_enable); end
        idle();
        n_vec++; if (w_enable !== 1'b1 || w_addr1 !== 5'd3 || w_data1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_write: got we=%0b a=%0d d=%h want we=1 a=3 d=deadbeef", w_enable, w_addr1, w_data1); end
        n_vec++; if (pending !== 32'h8 || count !== 3'd0) begin n_err++; $display("FAIL single_pending2: got p=%h c=%0d want p=00000008 c=0", pending, count); end
        idle();
        n_vec++; if (w_enable !== 1'b0 || pending !== 32'd0) begin n_err++; $display("FAIL single_done: got we=%0b p=%h want we=0 p=0", w_enable, pending); end
        $display("test_single done");
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        n_vec++; if (count !== 3'd2 || pending !== 32'h20) begin n_err++; $display("FAIL simul_enq: got c=%0d p=%h want c=2 p=00000020", count, pending); end
        idle();
        n_vec++; if (w_enable !== 1'b1 || w_addr1 !== 5'd5 || w_data1 !== 32'h11) begin n_err++; $display("FAIL simul_first: got we=%0b a=%0d d=%h want we=1 a=5 d=11", w_enable, w_addr1, w_data1); end
        n_vec++; if (pending !== 32'h20) begin n_err++; $display("FAIL simul_pending1: got %h want 00000020", pending); end
        idle();
        n_vec++; if (w_enable !== 1'b1 || w_addr1 !== 5'd5 || w_data1 !== 32'h22) begin n_err++; $display("FAIL simul_second: got we=%0b a=%0d d=%h want we=1 a=5 d=22", w_enable, w_addr1, w_data1); end
        n_vec++; if (pending !== 32'h20 || count !== 3'd0) begin n_err++; $display("FAIL simul_pending2: got p=%h c=%0d want p=00000020 c=0", pending, count); end
        idle();
        n_vec++; if (w_enable !== 1'b0 || pending !== 32'd0) begin n_err++; $display("FAIL simul_done: got we=%0b p=%h want 0/0", w_enable, pending); end
        $display("test_simultaneous done");
    endtask

    task automatic test_r0();
        n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL r0_alu_ready: got %0b want 1", alu_ready); end
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        n_vec++; if (count !== 3'd0 || pending !== 32'd0) begin n_err++; $display("FAIL r0_count: got c=%0d p=%h want 0/0", count, pending); end
        idle();
        n_vec++; if (w_enable !== 1'b0 || pending !== 32'd0) begin n_err++; $display("FAIL r0_nowrite: got we=%0b p=%h want 0/0", w_enable, pending); end
        cycle(1'b1, 5'd0, 32'hAA, 1'b1, 5'd7, 32'h77);
        n_vec++; if (count !== 3'd1 || pending !== 32'h80) begin n_err++; $display("FAIL r0_mixed_enq: got c=%0d p=%h want c=1 p=00000080", count, pending); end
        idle();
        n_vec++; if (w_enable !== 1'b1 || w_addr1 !== 5'd7 || w_data1 !== 32'h77) begin n_err++; $display("FAIL r0_mixed_write: got we=%0b a=%0d d=%h want we=1 a=7 d=77", w_enable, w_addr1, w_data1); end
        idle();
        n_vec++; if (w_enable !== 1'b0) begin n_err++; $display("FAIL r0_mixed_done: got we=%0b want 0", w_enable); end
        $display("test_r0 done");
    endtask

    task automatic test_fill_random();
        logic mv, av;
        for (int i = 0; i < 26; i++) begin
            if (i < 3) begin
                mv = 1'b1; av = 1'b1;
            end else if (i < 20) begin
                mv = ($urandom_range(0, 3) != 0);
                av = ($urandom_range(0, 3) != 0);
            end else begin
                mv = 1'b0; av = 1'b0;
            end
            cycle(mv, 5'($urandom_range(0, 31)), $urandom(), av, 5'($urandom_range(0, 31)), $urandom());
            n_vec++; if (count !== 3'(mq.size())) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, mq.size()); end
            n_vec++; if (count > 3'(DEPTH)) begin n_err++; $display("FAIL fill_overflow[%0d]: got %0d want <= %0d", i, count, DEPTH); end
            n_vec++; if (mem_ready !== (mq.size() <= DEPTH - 1)) begin n_err++; $display("FAIL fill_mem_ready[%0d]: got %0b want %0b", i, mem_ready, mq.size() <= DEPTH - 1); end
            n_vec++; if (alu_ready !== (mq.size() <= DEPTH - 2)) begin n_err++; $display("FAIL fill_alu_ready[%0d]: got %0b want %0b", i, alu_ready, mq.size() <= DEPTH - 2); end
            n_vec++; if (w_enable !== m_we) begin n_err++; $display("FAIL fill_wen[%0d]: got %0b want %0b", i, w_enable, m_we); end
            if (m_we) begin
                n_vec++; if (w_addr1 !== m_wa || w_data1 !== m_wd) begin n_err++; $display("FAIL fill_write[%0d]: got a=%0d d=%h want a=%0d d=%h", i, w_addr1, w_data1, m_wa, m_wd); end
            end
            n_vec++; if (pending !== model_pending()) begin n_err++; $display("FAIL fill_pending[%0d]: got %h want %h", i, pending, model_pending()); end
        end
        $display("test_fill_random done");
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h202);
        cycle(1'b1, 5'd3, 32'h303, 1'b1, 5'd4, 32'h404);
        n_vec++; if (count !== 3'd3 || w_enable !== 1'b1) begin n_err++; $display("FAIL areset_pre: got c=%0d we=%0b want c=3 we=1", count, w_enable); end
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_vec++; if (w_enable !== 1'b0 || w_addr1 !== 5'd0 || w_data1 !== 32'd0) begin n_err++; $display("FAIL areset_port: got we=%0b a=%0d d=%h want all 0", w_enable, w_addr1, w_data1); end
        n_vec++; if (count !== 3'd0 || pending !== 32'd0) begin n_err++; $display("FAIL areset_state: got c=%0d p=%h want 0/0", count, pending); end
        n_vec++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0) begin n_err++; $display("FAIL areset_ready: got %0b%0b want 00", mem_ready, alu_ready); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle();
        n_vec++; if (w_enable !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL areset_after: got we=%0b c=%0d want 0/0", w_enable, count); end
        cycle(1'b1, 5'd6, 32'hC0FFEE, 1'b0, 5'd0, 32'd0);
        n_vec++; if (count !== 3'd1 || pending !== 32'h40) begin n_err++; $display("FAIL areset_push: got c=%0d p=%h want c=1 p=00000040", count, pending); end
        idle();
        n_vec++; if (w_enable !== 1'b1 || w_addr1 !== 5'd6 || w_data1 !== 32'hC0FFEE) begin n_err++; $display("FAIL areset_write: got we=%0b a=%0d d=%h want we=1 a=6 d=c0ffee", w_enable, w_addr1, w_data1); end
        idle();
        $display("test_async_reset done");
    endtask

    task automatic test_wrap();
        logic [31:0] wd [1:10];
        for (int k = 1; k <= 10; k++) wd[k] = $urandom();
        for (int k = 1; k <= 11; k++) begin
            if (k <= 10) cycle(1'b1, 5'(k), wd[k], 1'b0, 5'd0, 32'd0);
            else idle();
            if (k <= 10) begin
                n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want 1", k, count); end
            end
            if (k >= 2) begin
                n_vec++; if (w_enable !== 1'b1 || w_addr1 !== 5'(k - 1) || w_data1 !== wd[k - 1]) begin n_err++; $display("FAIL wrap_write[%0d]: got we=%0b a=%0d d=%h want we=1 a=%0d d=%h", k, w_enable, w_addr1, w_data1, k - 1, wd[k - 1]); end
            end
        end
        idle();
        n_vec++; if (w_enable !== 1'b0 || count !== 3'd0 || pending !== 32'd0) begin n_err++; $display("FAIL wrap_done: got we=%0b c=%0d p=%h want 0/0/0", w_enable, count, pending); end
        $display("test_wrap done");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_r0();
        test_fill_random();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
